// File: rtl/rf_commit_ctrl.sv
// Register-file commit sequencer: buffers ROB commits in a small FIFO, drives isolated
// regfile write strobes and keeps per-register busy/tag rename status. Option: REG0_HARDWIRE_EN.
`timescale 1ns/1ps
module rf_commit_ctrl #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int TAGW  = 4,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_reg,
  input  logic [TAGW-1:0] issue_tag,
  input  logic [AW-1:0]   lk_reg1,
  output logic            lk_busy1,
  output logic [TAGW-1:0] lk_tag1,
  input  logic [AW-1:0]   lk_reg2,
  output logic            lk_busy2,
  output logic [TAGW-1:0] lk_tag2,
  input  logic            cm_valid,
  output logic            cm_ready,
  input  logic [AW-1:0]   cm_reg,
  input  logic [TAGW-1:0] cm_tag,
  input  logic [DW-1:0]   cm_data,
  input  logic            flush,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [DW-1:0]   rf_wdata,
  output logic [AW:0]     fifo_count,
  output logic [1:0]      dbg_state
);

  // Commit handshake: an entry transfers on a rising edge where cm_valid && cm_ready;
  // cm_ready depends only on the registered count, never on cm_valid.

`ifdef REG0_HARDWIRE_EN
  localparam bit REG0_HW = 1'b1;
`else
  localparam bit REG0_HW = 1'b0;
`endif

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, STROBE = 2'd1, GAP = 2'd2} state_t;

  state_t            state_q;
  logic [NREG-1:0]   busy_q, busy_d;
  logic [TAGW-1:0]   tag_q [NREG];
  logic [TAGW-1:0]   tag_d [NREG];
  logic [AW-1:0]     mem_reg  [DEPTH];
  logic [DW-1:0]     mem_data [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              push, pop, issue_ok;
  logic [AW-1:0]     head_reg;
  logic [DW-1:0]     head_data;

  assign cm_ready   = (count_q < (AW+1)'(DEPTH));
  assign push       = cm_valid & cm_ready;
  assign pop        = (state_q == STROBE);
  assign fifo_count = count_q;
  assign dbg_state  = state_q;
  assign head_reg   = mem_reg[rd_ptr_q];
  assign head_data  = mem_data[rd_ptr_q];
  assign issue_ok   = issue_valid & ~(REG0_HW & (issue_reg == '0));

  assign lk_busy1 = busy_q[lk_reg1] & ~(REG0_HW & (lk_reg1 == '0));
  assign lk_tag1  = tag_q[lk_reg1];
  assign lk_busy2 = busy_q[lk_reg2] & ~(REG0_HW & (lk_reg2 == '0));
  assign lk_tag2  = tag_q[lk_reg2];

  // Issue is applied after the commit clear so a same-register issue wins.
  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (push && busy_q[cm_reg] && (tag_q[cm_reg] == cm_tag))
        busy_d[cm_reg] = 1'b0;
      if (issue_ok) begin
        busy_d[issue_reg] = 1'b1;
        tag_d[issue_reg]  = issue_tag;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      for (int i = 0; i < NREG; i++) tag_q[i] <= '0;
    end else begin
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_q]  <= cm_reg;
      mem_data[wr_ptr_q] <= cm_data;
    end
  end

  // The head is popped on leaving STROBE, so GAP already sees the next entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      case (state_q)
        IDLE, GAP: begin
          if (count_q != '0) begin
            rf_waddr <= head_reg;
            rf_wdata <= head_data;
            rf_we    <= ~(REG0_HW & (head_reg == '0));
            state_q  <= STROBE;
          end else begin
            rf_we   <= 1'b0;
            state_q <= IDLE;
          end
        end
        STROBE: begin
          rf_we   <= 1'b0;
          state_q <= GAP;
        end
        default: begin
          rf_we   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_commit_ctrl.sv
// Bench for rf_commit_ctrl: directed scenarios plus random traffic against a queue/array
// reference model of rename status, FIFO occupancy and the ordered stream of regfile writes.
`timescale 1ns/1ps
module tb_rf_commit_ctrl;
  localparam int NREG = 32, AW = 5, DW = 32, TAGW = 4, DEPTH = 4;
`ifdef REG0_HARDWIRE_EN
  localparam bit HW = 1'b1;
`else
  localparam bit HW = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic issue_valid = 1'b0, cm_valid = 1'b0, flush = 1'b0;
  logic [AW-1:0] issue_reg = '0, lk_reg1 = '0, lk_reg2 = '0, cm_reg = '0;
  logic [TAGW-1:0] issue_tag = '0, cm_tag = '0;
  logic [DW-1:0] cm_data = '0;
  logic lk_busy1, lk_busy2, cm_ready, rf_we;
  logic [TAGW-1:0] lk_tag1, lk_tag2;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW:0] fifo_count;
  logic [1:0] dbg_state;

  rf_commit_ctrl #(.NREG(NREG), .AW(AW), .DW(DW), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .issue_tag(issue_tag),
    .lk_reg1(lk_reg1), .lk_busy1(lk_busy1), .lk_tag1(lk_tag1),
    .lk_reg2(lk_reg2), .lk_busy2(lk_busy2), .lk_tag2(lk_tag2),
    .cm_valid(cm_valid), .cm_ready(cm_ready), .cm_reg(cm_reg), .cm_tag(cm_tag),
    .cm_data(cm_data), .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fifo_count(fifo_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // reference model
  bit                  m_busy [NREG];
  logic [TAGW-1:0]     m_tag  [NREG];
  int                  m_count;
  logic [AW+DW-1:0]    exp_q[$];
  bit                  we_last, last_acc, saw_full, track_count = 1'b1;
  int                  writes_seen;
  int                  n_checks, n_errors;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin m_busy[i] = 1'b0; m_tag[i] = '0; end
    exp_q.delete();
    m_count = 0;
    we_last = 1'b0;
  endtask

  task automatic check_outputs();
    logic [AW+DW-1:0] e;
    if (track_count) begin
      check("cm_ready", cm_ready, m_count < DEPTH);
      check("fifo_count", fifo_count, m_count);
    end
    check("lk_busy1", lk_busy1, m_busy[lk_reg1]);
    check("lk_tag1", lk_tag1, m_tag[lk_reg1]);
    check("lk_busy2", lk_busy2, m_busy[lk_reg2]);
    check("lk_tag2", lk_tag2, m_tag[lk_reg2]);
    if (!cm_ready) saw_full = 1'b1;
    if (rf_we) begin
      writes_seen++;
      check("we_back_to_back", we_last, 1'b0);
      if (exp_q.size() == 0) check("spurious_we", 1'b1, 1'b0);
      else begin
        e = exp_q.pop_front();
        check("rf_waddr", rf_waddr, e[AW+DW-1:DW]);
        check("rf_wdata", rf_wdata, e[DW-1:0]);
      end
    end
    we_last = rf_we;
  endtask

  // One clock: apply the driven inputs to the model at the edge, check at the falling edge.
  task automatic step();
    bit was_we;
    @(posedge clk);
    was_we   = we_last;
    last_acc = cm_valid && (m_count < DEPTH);
    if (flush) begin
      for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    end else begin
      if (last_acc && m_busy[cm_reg] && m_tag[cm_reg] == cm_tag) m_busy[cm_reg] = 1'b0;
      if (issue_valid && !(HW && issue_reg == 0)) begin
        m_busy[issue_reg] = 1'b1;
        m_tag[issue_reg]  = issue_tag;
      end
    end
    if (last_acc) begin
      m_count++;
      if (!(HW && cm_reg == 0)) exp_q.push_back({cm_reg, cm_data});
    end
    if (was_we) m_count--;
    @(negedge clk);
    check_outputs();
  endtask

  // driver tasks
  task automatic drive_idle();
    issue_valid = 1'b0; cm_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic do_issue(input logic [AW-1:0] r, input logic [TAGW-1:0] t);
    issue_valid = 1'b1; issue_reg = r; issue_tag = t;
    step();
    issue_valid = 1'b0;
  endtask

  task automatic do_commit(input logic [AW-1:0] r, input logic [TAGW-1:0] t, input logic [DW-1:0] d);
    cm_valid = 1'b1; cm_reg = r; cm_tag = t; cm_data = d;
    last_acc = 1'b0;
    for (int i = 0; i < 20 && !last_acc; i++) step();
    if (!last_acc) check("commit_timeout", 1'b0, 1'b1);
    cm_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (exp_q.size() != 0 || m_count != 0); i++) step();
    check("drain_left", exp_q.size(), 0);
    step();
    step();
  endtask

  function automatic logic [AW-1:0] rand_reg();
    return AW'($urandom_range(HW ? 1 : 0, NREG - 1));
  endfunction

  initial begin
    int w0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_cm_ready", cm_ready, 1'b1);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_state", dbg_state, 2'd0);
    for (int i = 0; i < NREG; i += 2) begin
      lk_reg1 = AW'(i); lk_reg2 = AW'(i + 1);
      step();
      check("rst_lk_busy1", lk_busy1, 1'b0);
      check("rst_lk_busy2", lk_busy2, 1'b0);
    end

    // rename then matching commit, with first-write latency
    do_issue(5, 3);
    lk_reg1 = 5;
    #1;
    check("t2_busy_set", lk_busy1, 1'b1);
    check("t2_tag_set", lk_tag1, 3);
    do_commit(5, 3, 32'hDEADBEEF);
    check("t2_busy_clr", lk_busy1, 1'b0);
    check("t2_no_we_yet", rf_we, 1'b0);
    step();
    check("t2_we", rf_we, 1'b1);
    check("t2_waddr", rf_waddr, 5);
    check("t2_wdata", rf_wdata, 32'hDEADBEEF);
    drain();

    // stale tag commit leaves the newer rename intact
    do_issue(7, 2);
    do_issue(7, 6);
    do_commit(7, 2, 32'h0000_0777);
    lk_reg1 = 7;
    #1;
    check("t3_busy", lk_busy1, 1'b1);
    check("t3_tag", lk_tag1, 6);
    w0 = writes_seen;
    drain();
    check("t3_written", writes_seen - w0, 1);

    // back-to-back burst fills the FIFO
    saw_full = 1'b0;
    w0 = writes_seen;
    for (int i = 0; i < 10; i++) do_commit(rand_reg(), TAGW'($urandom), $urandom);
    check("t4_saw_full", saw_full, 1'b1);
    drain();
    check("t4_written", writes_seen - w0, 10);

    // flush with queued entries
    do_issue(3, 1);
    do_issue(9, 2);
    do_issue(12, 4);
    w0 = writes_seen;
    do_commit(3, 5, 32'h3333);
    do_commit(9, 6, 32'h9999);
    do_commit(12, 7, 32'hCCCC);
    flush = 1'b1;
    issue_valid = 1'b1; issue_reg = 20; issue_tag = 9;
    step();
    drive_idle();
    for (int i = 0; i < NREG; i += 2) begin
      lk_reg1 = AW'(i); lk_reg2 = AW'(i + 1);
      step();
      check("t5_busy1", lk_busy1, 1'b0);
      check("t5_busy2", lk_busy2, 1'b0);
    end
    drain();
    check("t5_written", writes_seen - w0, 3);

    // reset asserted during a write strobe
    do_commit(1, 0, 32'h1111);
    do_commit(2, 0, 32'h2222);
    do_commit(4, 0, 32'h4444);
    for (int i = 0; i < 20 && !rf_we; i++) step();
    check("t6_saw_strobe", rf_we, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_we_drop", rf_we, 1'b0);
    check("t6_count", fifo_count, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    w0 = writes_seen;
    repeat (12) step();
    check("t6_no_writes", writes_seen - w0, 0);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_reg   = rand_reg();
      issue_tag   = TAGW'($urandom);
      cm_valid    = ($urandom_range(0, 1) == 1);
      cm_reg      = rand_reg();
      cm_tag      = ($urandom_range(0, 1) == 1) ? m_tag[cm_reg] : TAGW'($urandom);
      cm_data     = $urandom;
      flush       = ($urandom_range(0, 24) == 0);
      lk_reg1     = rand_reg();
      lk_reg2     = ($urandom_range(0, 1) == 1) ? issue_reg : cm_reg;
      step();
    end
    drive_idle();
    drain();

`ifdef REG0_HARDWIRE_EN
    do_issue(0, 1);
    lk_reg1 = 0;
    #1;
    check("hw_busy_r0", lk_busy1, 1'b0);
    track_count = 1'b0;
    w0 = writes_seen;
    do_commit(0, 1, 32'h1);
    repeat (8) begin
      step();
      check("hw_no_we", rf_we, 1'b0);
    end
    check("hw_writes", writes_seen - w0, 0);
    check("hw_count", fifo_count, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
